reset_sequencer: RTL and testbench

//   Consumes the clk/resetn pair from the clock/reset front end. Produces glitch-free,

---
 rtl/reset_sequencer.sv | 176 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: turns the board clk/resetn pair into staged, clock-synchronous
// active-low resets for the memory, peripheral and CPU domains, and handles a
// CPU-requested soft reset that re-resets peripherals and CPU while memory keeps running.
module reset_sequencer #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 4,
  parameter int unsigned SOFT_CYCLES = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic soft_req,
  output logic soft_ack,
  output logic mem_resetn,
  output logic periph_resetn,
  output logic cpu_resetn,
  output logic ready
);

  // Counter is sized for the longest interval so it can never wrap.
  localparam int unsigned MAX_AB   = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int unsigned MAX_ALL  = (MAX_AB > SOFT_CYCLES) ? MAX_AB : SOFT_CYCLES;
  localparam int unsigned CNT_W    = $clog2(MAX_ALL + 1);

  // Terminal counts: the transition fires on the N-th counted edge.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    HOLD       = 3'd0,
    REL_MEM    = 3'd1,
    REL_PERIPH = 3'd2,
    RUN        = 3'd3,
    SOFT       = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic sync_meta;
  logic rst_sync;
  logic req_q;

  logic soft_ack_nxt;
  logic mem_resetn_nxt;
  logic periph_resetn_nxt;
  logic cpu_resetn_nxt;
  logic ready_nxt;

  logic trigger;

  // Rising level of the soft request relative to the previous sample.
  assign trigger = soft_req & ~req_q;

  // Two-flop synchroniser for the resetn release edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_meta <= 1'b0;
      rst_sync  <= 1'b0;
    end else begin
      sync_meta <= 1'b1;
      rst_sync  <= sync_meta;
    end
  end

  // Soft-request history; tracks the input in every state so a held level
  // cannot retrigger on return to RUN.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_q <= 1'b0;
    end else begin
      req_q <= soft_req;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= HOLD;
      cnt           <= '0;
      soft_ack      <= 1'b0;
      mem_resetn    <= 1'b0;
      periph_resetn <= 1'b0;
      cpu_resetn    <= 1'b0;
      ready         <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      soft_ack      <= soft_ack_nxt;
      mem_resetn    <= mem_resetn_nxt;
      periph_resetn <= periph_resetn_nxt;
      cpu_resetn    <= cpu_resetn_nxt;
      ready         <= ready_nxt;
    end
  end

  // Next-state, counter and output decode; nothing advances until rst_sync is high.
  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    soft_ack_nxt      = 1'b0;
    mem_resetn_nxt    = mem_resetn;
    periph_resetn_nxt = periph_resetn;
    cpu_resetn_nxt    = cpu_resetn;
    ready_nxt         = ready;

    if (rst_sync) begin
      case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            mem_resetn_nxt = 1'b1;
            state_nxt      = REL_MEM;
            cnt_nxt        = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end

        REL_MEM: begin
          if (cnt == GAP_LAST) begin
            periph_resetn_nxt = 1'b1;
            state_nxt         = REL_PERIPH;
            cnt_nxt           = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end

        REL_PERIPH: begin
          if (cnt == GAP_LAST) begin
            cpu_resetn_nxt = 1'b1;
            ready_nxt      = 1'b1;
            state_nxt      = RUN;
            cnt_nxt        = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end

        RUN: begin
          cnt_nxt = '0;
          if (trigger) begin
            soft_ack_nxt      = 1'b1;
            periph_resetn_nxt = 1'b0;
            cpu_resetn_nxt    = 1'b0;
            ready_nxt         = 1'b0;
            state_nxt         = SOFT;
          end
        end

        SOFT: begin
          if (cnt == SOFT_LAST) begin
            periph_resetn_nxt = 1'b1;
            state_nxt         = REL_PERIPH;
            cnt_nxt           = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end

        default: begin
          state_nxt         = HOLD;
          cnt_nxt           = '0;
          mem_resetn_nxt    = 1'b0;
          periph_resetn_nxt = 1'b0;
          cpu_resetn_nxt    = 1'b0;
          ready_nxt         = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default-parameter instance and a 1/1/1 instance,
// both checked every cycle against an edge-count schedule model.
module tb_reset_sequencer;

  localparam int H_P [2] = '{16, 1};
  localparam int G_P [2] = '{4, 1};
  localparam int S_P [2] = '{8, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rn0, rn1, req0, req1;
  logic ack0, mem0, per0, cpu0, rdy0;
  logic ack1, mem1, per1, cpu1, rdy1;

  int vectors    = 0;
  int miscompares = 0;

  reset_sequencer dut0 (
    .clk(clk), .resetn(rn0), .soft_req(req0), .soft_ack(ack0),
    .mem_resetn(mem0), .periph_resetn(per0), .cpu_resetn(cpu0), .ready(rdy0)
  );

  reset_sequencer #(.HOLD_CYCLES(1), .STAGE_GAP(1), .SOFT_CYCLES(1)) dut1 (
    .clk(clk), .resetn(rn1), .soft_req(req1), .soft_ack(ack1),
    .mem_resetn(mem1), .periph_resetn(per1), .cpu_resetn(cpu1), .ready(rdy1)
  );

  // Observed outputs packed as {mem, periph, cpu, ready, ack}.
  logic [4:0] obs [2];
  assign obs[0] = {mem0, per0, cpu0, rdy0, ack0};
  assign obs[1] = {mem1, per1, cpu1, rdy1, ack1};

  // Reference model: n = rising edges seen since resetn went high; each domain is
  // released at a scheduled edge number, a soft trigger reschedules periph/cpu.
  int         n      [2];
  int         mem_at [2];
  int         per_at [2];
  int         cpu_at [2];
  logic       prev   [2];
  logic [4:0] exp_o  [2];

  task automatic model_reset(input int i);
    n[i]      = 0;
    mem_at[i] = 2 + H_P[i];
    per_at[i] = 2 + H_P[i] + G_P[i];
    cpu_at[i] = 2 + H_P[i] + 2 * G_P[i];
    prev[i]   = 1'b0;
    exp_o[i]  = 5'b0;
  endtask

  task automatic model_edge(input int i, input logic req);
    logic trig;
    n[i] = n[i] + 1;
    trig = (n[i] > cpu_at[i]) && req && !prev[i];
    prev[i] = req;
    if (trig) begin
      per_at[i] = n[i] + S_P[i];
      cpu_at[i] = n[i] + S_P[i] + G_P[i];
    end
    exp_o[i] = {n[i] >= mem_at[i], n[i] >= per_at[i], n[i] >= cpu_at[i],
                n[i] >= cpu_at[i], trig};
  endtask

  always @(posedge clk or negedge rn0) begin
    if (!rn0) model_reset(0);
    else      model_edge(0, req0);
  end

  always @(posedge clk or negedge rn1) begin
    if (!rn1) model_reset(1);
    else      model_edge(1, req1);
  end

  task automatic test_reset();
    rn0 = 1'b0; rn1 = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs[i] !== 5'b0) begin
        miscompares++;
        $display("FAIL reset inst%0d: got %b want 00000", i, obs[i]);
      end
    end
  endtask

  task automatic test_power_up();
    int mem_edge, per_edge, cpu_edge;
    mem_edge = -1; per_edge = -1; cpu_edge = -1;
    rn0 = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      vectors++;
      if (obs[0] !== exp_o[0]) begin
        miscompares++;
        $display("FAIL power_up cyc %0d: got %b want %b", c, obs[0], exp_o[0]);
      end
      if (mem0 && mem_edge < 0) mem_edge = c;
      if (per0 && per_edge < 0) per_edge = c;
      if (cpu0 && rdy0 && cpu_edge < 0) cpu_edge = c;
    end
    vectors += 3;
    if (mem_edge !== 18) begin
      miscompares++; $display("FAIL power_up mem edge: got E%0d want E18", mem_edge);
    end
    if (per_edge !== 22) begin
      miscompares++; $display("FAIL power_up periph edge: got E%0d want E22", per_edge);
    end
    if (cpu_edge !== 26) begin
      miscompares++; $display("FAIL power_up cpu edge: got E%0d want E26", cpu_edge);
    end
  endtask

  task automatic test_soft_reset();
    int acks, hold_len, per_edge, cpu_edge;
    acks = 0; per_edge = -1; cpu_edge = -1;
    hold_len = int'($urandom_range(1, 3));
    repeat (int'($urandom_range(1, 5))) begin
      @(negedge clk);
      vectors++;
      if (obs[0] !== exp_o[0]) begin
        miscompares++;
        $display("FAIL soft_idle: got %b want %b", obs[0], exp_o[0]);
      end
    end
    req0 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      vectors++;
      if (obs[0] !== exp_o[0]) begin
        miscompares++;
        $display("FAIL soft_reset cyc %0d: got %b want %b", c, obs[0], exp_o[0]);
      end
      if (ack0) acks++;
      if (per0 && per_edge < 0 && c > 1) per_edge = c;
      if (cpu0 && cpu_edge < 0 && c > 1) cpu_edge = c;
      if (c == hold_len) req0 = 1'b0;
    end
    vectors += 3;
    if (acks !== 1) begin
      miscompares++; $display("FAIL soft_reset ack count: got %0d want 1", acks);
    end
    if (per_edge !== 9) begin
      miscompares++; $display("FAIL soft_reset periph: got Ek+%0d want Ek+8", per_edge - 1);
    end
    if (cpu_edge !== 13) begin
      miscompares++; $display("FAIL soft_reset cpu: got Ek+%0d want Ek+12", cpu_edge - 1);
    end
  endtask

  task automatic test_soft_hold();
    int acks;
    acks = 0;
    req0 = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      vectors++;
      if (obs[0] !== exp_o[0]) begin
        miscompares++;
        $display("FAIL soft_hold cyc %0d: got %b want %b", c, obs[0], exp_o[0]);
      end
      if (ack0) acks++;
      if (c == 40) req0 = 1'b0;
    end
    req0 = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      vectors++;
      if (obs[0] !== exp_o[0]) begin
        miscompares++;
        $display("FAIL soft_hold re cyc %0d: got %b want %b", c, obs[0], exp_o[0]);
      end
      if (ack0) acks++;
      if (c == 2) req0 = 1'b0;
    end
    vectors++;
    if (acks !== 2) begin
      miscompares++; $display("FAIL soft_hold ack count: got %0d want 2", acks);
    end
  endtask

  task automatic test_ignored();
    int acks, mem_edge;
    acks = 0; mem_edge = -1;
    req0 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      vectors++;
      if (obs[0] !== exp_o[0]) begin
        miscompares++;
        $display("FAIL ignored_soft cyc %0d: got %b want %b", c, obs[0], exp_o[0]);
      end
      if (ack0) acks++;
      if (c == 3) req0 = 1'b0;
      if (c == 5) req0 = 1'b1;
      if (c == 6) req0 = 1'b0;
    end
    rn0 = 1'b0;
    repeat (2) @(negedge clk);
    rn0 = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      vectors++;
      if (obs[0] !== exp_o[0]) begin
        miscompares++;
        $display("FAIL ignored_hold cyc %0d: got %b want %b", c, obs[0], exp_o[0]);
      end
      if (ack0) acks++;
      if (mem0 && mem_edge < 0) mem_edge = c;
      req0 = (c < 16) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    vectors += 2;
    if (acks !== 1) begin
      miscompares++; $display("FAIL ignored ack count: got %0d want 1", acks);
    end
    if (mem_edge !== 18) begin
      miscompares++; $display("FAIL ignored mem edge: got E%0d want E18", mem_edge);
    end
  endtask

  task automatic test_async_assert();
    int mem_edge, per_edge, cpu_edge;
    for (int pass = 0; pass < 2; pass++) begin
      mem_edge = -1; per_edge = -1; cpu_edge = -1;
      rn0 = 1'b0;
      @(negedge clk);
      rn0 = 1'b1;
      // pass 0 stops in REL_PERIPH; pass 1 reaches RUN then enters SOFT
      for (int c = 1; c <= ((pass == 0) ? 23 : 34); c++) begin
        @(negedge clk);
        vectors++;
        if (obs[0] !== exp_o[0]) begin
          miscompares++;
          $display("FAIL async_pre p%0d cyc %0d: got %b want %b", pass, c, obs[0], exp_o[0]);
        end
        req0 = (pass == 1 && c >= 28 && c < 30);
      end
      #2 rn0 = 1'b0;
      #1;
      vectors++;
      if (obs[0] !== 5'b0) begin
        miscompares++;
        $display("FAIL async_drop p%0d: got %b want 00000", pass, obs[0]);
      end
      req0 = 1'b0;
      repeat (2) @(negedge clk);
      rn0 = 1'b1;
      for (int c = 1; c <= 30; c++) begin
        @(negedge clk);
        vectors++;
        if (obs[0] !== exp_o[0]) begin
          miscompares++;
          $display("FAIL async_rel p%0d cyc %0d: got %b want %b", pass, c, obs[0], exp_o[0]);
        end
        if (mem0 && mem_edge < 0) mem_edge = c;
        if (per0 && per_edge < 0) per_edge = c;
        if (cpu0 && cpu_edge < 0) cpu_edge = c;
      end
      vectors++;
      if (mem_edge !== 18 || per_edge !== 22 || cpu_edge !== 26) begin
        miscompares++;
        $display("FAIL async_rel p%0d edges: got E%0d/E%0d/E%0d want E18/E22/E26",
                 pass, mem_edge, per_edge, cpu_edge);
      end
    end
  endtask

  task automatic test_min_params();
    int mem_edge, per_edge, cpu_edge;
    mem_edge = -1; per_edge = -1; cpu_edge = -1;
    rn1 = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      vectors++;
      if (obs[1] !== exp_o[1]) begin
        miscompares++;
        $display("FAIL min_up cyc %0d: got %b want %b", c, obs[1], exp_o[1]);
      end
      if (mem1 && mem_edge < 0) mem_edge = c;
      if (per1 && per_edge < 0) per_edge = c;
      if (cpu1 && cpu_edge < 0) cpu_edge = c;
    end
    vectors++;
    if (mem_edge !== 3 || per_edge !== 4 || cpu_edge !== 5) begin
      miscompares++;
      $display("FAIL min_up edges: got E%0d/E%0d/E%0d want E3/E4/E5",
               mem_edge, per_edge, cpu_edge);
    end
    // explicit trigger: periph back at Ek+1, cpu at Ek+2
    req1 = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs[1] !== 5'b10001) begin
      miscompares++; $display("FAIL min_soft Ek: got %b want 10001", obs[1]);
    end
    req1 = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs[1] !== 5'b11000) begin
      miscompares++; $display("FAIL min_soft Ek+1: got %b want 11000", obs[1]);
    end
    @(negedge clk);
    vectors++;
    if (obs[1] !== 5'b11110) begin
      miscompares++; $display("FAIL min_soft Ek+2: got %b want 11110", obs[1]);
    end
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      vectors++;
      if (obs[1] !== exp_o[1] || (per1 && !mem1) || (cpu1 && !per1)) begin
        miscompares++;
        $display("FAIL min_rand cyc %0d: got %b want %b", c, obs[1], exp_o[1]);
      end
      req1 = 1'($urandom_range(0, 1));
    end
    req1 = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      vectors++;
      if (obs[0] !== exp_o[0] || (per0 && !mem0) || (cpu0 && !per0)) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %b want %b", c, obs[0], exp_o[0]);
      end
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if (!rn0) rn0 = 1'b1;
      else if ($urandom_range(0, 149) == 0) rn0 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_soft_reset();
    test_soft_hold();
    test_ignored();
    test_async_assert();
    test_min_params();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
